// File: rtl/sd_clk_divider_if.sv
// Control/status bundle between an SD host controller and the SD clock generator.
interface sd_clk_divider_if #(
    parameter int DIV_W = 10
);
    logic             clk_en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             sd_clk;
    logic             pos_stb;
    logic             neg_stb;
    logic             div_done;
    logic             ready;
    logic             running;

    // div_load is a one-cycle request with no back-pressure; div_done is the
    // one-cycle acknowledge when the pending divisor becomes the active one.
    modport master (
        output clk_en, div_val, div_load,
        input  sd_clk, pos_stb, neg_stb, div_done, ready, running
    );

    modport slave (
        input  clk_en, div_val, div_load,
        output sd_clk, pos_stb, neg_stb, div_done, ready, running
    );
endinterface

// File: rtl/sd_clk_divider.sv
// SD-card clock generator: lock-qualified, glitch-free, runtime divisor, with
// launch/sample strobes aligned to the registered sd_clk.
module sd_clk_divider #(
    parameter int DIV_W    = 10,
    parameter int INIT_DIV = 62,
    parameter int LOCK_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pll_lock,
    sd_clk_divider_if.slave bus,
    output logic [1:0]      o_dbg_state
);
    localparam int LC_W = $clog2(LOCK_CYC + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        IDLE      = 2'd1,
        RUN       = 2'd2,
        STOPPING  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_lock_s1;
    logic             r_lock_s2;
    logic [LC_W-1:0]  r_lock_cnt;
    logic             w_ready;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_sd_clk;
    logic             r_pos_stb;
    logic             r_neg_stb;
    logic             r_div_done;
    logic             r_running;
    logic             w_active;
    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic             w_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_s1  <= 1'b0;
            r_lock_s2  <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_lock_s1 <= pll_lock;
            r_lock_s2 <= r_lock_s1;
            if (!r_lock_s2) begin
                r_lock_cnt <= '0;
            end else if (!w_ready) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end
    end

    assign w_ready = (r_lock_cnt == LC_W'(LOCK_CYC));

    // The divider keeps counting in RUN after clk_en drops only while sd_clk is
    // high, so a high phase always completes; a low phase is simply abandoned.
    assign w_active = r_lock_s2 &&
                      (((r_state == RUN) && (bus.clk_en || r_sd_clk)) || (r_state == STOPPING));
    assign w_tick   = w_active && (r_cnt == r_cur_div);
    assign w_rise   = w_tick && !r_sd_clk;
    assign w_fall   = w_tick && r_sd_clk;
    assign w_xfer   = r_pend && (w_fall || (r_state == IDLE) || (r_state == WAIT_LOCK));

    always_comb begin
        w_state_nxt = r_state;
        if (!r_lock_s2) begin
            w_state_nxt = WAIT_LOCK;
        end else begin
            case (r_state)
                WAIT_LOCK: if (w_ready) w_state_nxt = IDLE;
                IDLE:      if (bus.clk_en) w_state_nxt = RUN;
                RUN: begin
                    if (!bus.clk_en) begin
                        w_state_nxt = (r_sd_clk && !w_tick) ? STOPPING : IDLE;
                    end
                end
                STOPPING:  if (w_fall) w_state_nxt = IDLE;
                default:   w_state_nxt = WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= WAIT_LOCK;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN) || (w_state_nxt == STOPPING);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_sd_clk  <= 1'b0;
            r_pos_stb <= 1'b0;
            r_neg_stb <= 1'b0;
        end else begin
            r_pos_stb <= w_rise;
            r_neg_stb <= w_fall;
            if (w_active) begin
                if (w_tick) begin
                    r_sd_clk <= ~r_sd_clk;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_sd_clk <= 1'b0;
                r_cnt    <= '0;
            end
        end
    end

    // A load coinciding with a transfer stays pending; the older value moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_div  <= DIV_W'(INIT_DIV);
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_div_done <= 1'b0;
        end else begin
            r_div_done <= w_xfer;
            if (w_xfer) begin
                r_cur_div <= r_pend_div;
            end
            if (bus.div_load) begin
                r_pend_div <= bus.div_val;
                r_pend     <= 1'b1;
            end else if (w_xfer) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign bus.sd_clk   = r_sd_clk;
    assign bus.pos_stb  = r_pos_stb;
    assign bus.neg_stb  = r_neg_stb;
    assign bus.div_done = r_div_done;
    assign bus.ready    = w_ready;
    assign bus.running  = r_running;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_sd_clk_divider.sv
// Scoreboard bench for sd_clk_divider: expected output events (kind, cycle) are
// queued by the stimulus and consumed by an independent monitor.
module tb_sd_clk_divider;
    localparam int DIV_W = 10;

    // Event kinds, in the order the monitor reports them within one cycle.
    localparam int EV_POS      = 1;
    localparam int EV_NEG      = 2;
    localparam int EV_DONE     = 3;
    localparam int EV_RDY_UP   = 4;
    localparam int EV_RDY_DN   = 5;
    localparam int EV_RUN_UP   = 6;
    localparam int EV_RUN_DN   = 7;
    localparam int EV_FORCE_LO = 8;
    localparam int EV_RISE_NS  = 9;
    localparam int EV_POS_NE   = 10;
    localparam int EV_NEG_NE   = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pll_lock;
    logic [1:0]  dbg_state;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    logic        p_sd = 1'b0;
    logic        p_ready = 1'b0;
    logic        p_running = 1'b0;

    sd_clk_divider_if #(.DIV_W(DIV_W)) bus ();

    sd_clk_divider #(
        .DIV_W   (DIV_W),
        .INIT_DIV(62),
        .LOCK_CYC(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver tasks
    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic load_div(input int val);
        bus.div_val  = DIV_W'(val);
        bus.div_load = 1'b1;
        @(negedge clk);
        bus.div_load = 1'b0;
    endtask

    function automatic void push(input int kind, input int c);
        exp_q.push_back({4'(kind), 28'(c)});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    // Scoreboard
    task automatic expire();
        logic [31:0] e;
        while (exp_q.size() > 0 && exp_q[0][27:0] < 28'(cyc)) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL missed_event: got nothing, want kind %0d at cycle %0d", e[31:28], e[27:0]);
        end
    endtask

    task automatic observe(input int kind);
        logic [31:0] e;
        logic [31:0] got;
        got = {4'(kind), 28'(cyc)};
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, want none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e == got) n_pass++;
            else $display("FAIL event: got kind %0d at cycle %0d, want kind %0d at cycle %0d",
                          kind, cyc, e[31:28], e[27:0]);
        end
    endtask

    // Monitor
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            expire();
            if (bus.pos_stb) observe(EV_POS);
            if (bus.neg_stb) observe(EV_NEG);
            if (bus.div_done) observe(EV_DONE);
            if (bus.ready && !p_ready) observe(EV_RDY_UP);
            if (!bus.ready && p_ready) observe(EV_RDY_DN);
            if (bus.running && !p_running) observe(EV_RUN_UP);
            if (!bus.running && p_running) observe(EV_RUN_DN);
            if (!bus.sd_clk && p_sd && !bus.neg_stb) observe(EV_FORCE_LO);
            if (bus.sd_clk && !p_sd && !bus.pos_stb) observe(EV_RISE_NS);
            if (bus.pos_stb && !(bus.sd_clk && !p_sd)) observe(EV_POS_NE);
            if (bus.neg_stb && !(!bus.sd_clk && p_sd)) observe(EV_NEG_NE);
        end
        p_sd      = bus.sd_clk;
        p_ready   = bus.ready;
        p_running = bus.running;
    end

    // Stimulus
    initial begin
        int c0, a, q, s;
        rst_n        = 1'b0;
        pll_lock     = 1'b0;
        bus.clk_en   = 1'b0;
        bus.div_val  = '0;
        bus.div_load = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sd_clk", bus.sd_clk, 0);
        check("rst_pos_stb", bus.pos_stb, 0);
        check("rst_neg_stb", bus.neg_stb, 0);
        check("rst_div_done", bus.div_done, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_running", bus.running, 0);
        check("rst_state", dbg_state, 0);

        // Lock qualification with a one-cycle dropout at cycle 5
        c0 = cyc;
        push(EV_RDY_UP, c0 + 16);
        rst_n    = 1'b1;
        pll_lock = 1'b1;
        wait_to(c0 + 5);
        pll_lock = 1'b0;
        wait_to(c0 + 6);
        pll_lock = 1'b1;

        // Default rate: 126-cycle period, 63 high / 63 low
        a = c0 + 20;
        wait_to(a);
        push(EV_RUN_UP, a + 1);
        push(EV_POS, a + 64);
        push(EV_NEG, a + 127);
        push(EV_POS, a + 190);
        bus.clk_en = 1'b1;

        // Load 0 mid high phase: switch at the fall, then clk/2
        wait_to(a + 200);
        push(EV_NEG, a + 253);
        push(EV_DONE, a + 253);
        for (int k = 0; k < 5; k++) begin
            push(EV_POS, a + 254 + 2 * k);
            push(EV_NEG, a + 255 + 2 * k);
        end
        push(EV_RUN_DN, a + 264);
        load_div(0);
        wait_to(a + 263);
        bus.clk_en = 1'b0;

        // Divisor load while idle transfers on the following cycle
        wait_to(a + 270);
        push(EV_DONE, a + 272);
        load_div(3);

        // Run at divisor 3, then lose lock during a high phase
        wait_to(a + 280);
        push(EV_RUN_UP, a + 281);
        push(EV_POS, a + 285);
        push(EV_NEG, a + 289);
        push(EV_POS, a + 293);
        push(EV_RDY_DN, a + 296);
        push(EV_RUN_DN, a + 296);
        push(EV_FORCE_LO, a + 296);
        push(EV_RDY_UP, a + 308);
        push(EV_RUN_UP, a + 310);
        push(EV_POS, a + 314);
        push(EV_NEG, a + 318);
        push(EV_POS, a + 322);
        push(EV_NEG, a + 326);
        push(EV_POS, a + 330);
        bus.clk_en = 1'b1;
        wait_to(a + 293);
        pll_lock = 1'b0;
        wait_to(a + 296);
        check("lockloss_state", dbg_state, 0);
        wait_to(a + 298);
        pll_lock = 1'b1;

        // Asynchronous reset in the middle of a high phase
        wait_to(a + 331);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sd_clk", bus.sd_clk, 0);
        check("arst_pos_stb", bus.pos_stb, 0);
        check("arst_neg_stb", bus.neg_stb, 0);
        check("arst_div_done", bus.div_done, 0);
        check("arst_ready", bus.ready, 0);
        check("arst_running", bus.running, 0);

        // Release: clean 10-cycle qualification, then divisor back at 62
        wait_to(a + 334);
        q = cyc;
        s = q + 75;
        push(EV_RDY_UP, q + 10);
        push(EV_RUN_UP, q + 12);
        push(EV_POS, s);
        push(EV_NEG, s + 63);
        push(EV_POS, s + 126);
        push(EV_NEG, s + 189);
        push(EV_RUN_DN, s + 189);
        rst_n = 1'b1;

        // Stop 10 cycles into a high phase; the high phase completes
        wait_to(s + 135);
        bus.clk_en = 1'b0;
        wait_to(s + 150);
        check("stopping_state", dbg_state, 3);
        check("stopping_sd_clk", bus.sd_clk, 1);

        // Restart: first rise cur_div+1 cycles after RUN entry
        wait_to(s + 200);
        push(EV_RUN_UP, s + 201);
        push(EV_POS, s + 264);
        bus.clk_en = 1'b1;

        // Two loads in one high phase: only the last (1) is applied
        wait_to(s + 270);
        push(EV_NEG, s + 327);
        push(EV_DONE, s + 327);
        for (int k = 0; k < 4; k++) begin
            push(EV_POS, s + 329 + 4 * k);
            push(EV_NEG, s + 331 + 4 * k);
        end
        push(EV_RUN_DN, s + 343);
        load_div(5);
        wait_to(s + 280);
        load_div(1);
        wait_to(s + 342);
        bus.clk_en = 1'b0;

        wait_to(s + 360);
        #2;
        check("events_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sd_clk_divider.md
# sd_clk_divider

Parametrised SD-card clock generator running in the PLL output clock domain. It waits for a stable PLL lock, then produces a registered, 50 %-duty `sd_clk` from a runtime-programmable integer divisor, so identification runs at about 400 kHz and data transfer at up to clk/2. Divisor changes and start/stop are glitch-free. Edge strobes let the SD command/data engines launch and sample in the `clk` domain without using `sd_clk` as a clock.

## Interface
Parameters:
- `DIV_W`, 10: divisor width. Half-period is `div+1` clk cycles.
- `INIT_DIV`, 62: divisor after reset. With a 50 MHz `clk` this gives 396.8 kHz.
- `LOCK_CYC`, 1024: consecutive synchronised-lock cycles required before `ready`. Minimum 1.

Ports:
- `clk`  in  1: PLL output clock; the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pll_lock`  in  1: raw PLL lock, asynchronous to `clk`.
- `clk_en`  in  1: run request. 1 = toggle `sd_clk`; 0 = park it low.
- `div_val`  in  DIV_W: new divisor.
- `div_load`  in  1: one-cycle strobe that captures `div_val`.
- `sd_clk`  out  1: registered SD clock.
- `pos_stb`  out  1: high in the cycle `sd_clk` first reads 1.
- `neg_stb`  out  1: high in the cycle `sd_clk` first reads 0.
- `div_done`  out  1: one-cycle pulse when the pending divisor becomes active.
- `ready`  out  1: lock qualified; the block accepts `clk_en`.
- `running`  out  1: high in state RUN or STOPPING.

## Operation
- Lock qualification:
  - `pll_lock` passes through a 2-flop synchroniser into a saturating counter.
  - Any synchronised 0 clears the counter.
  - `ready` = counter has reached `LOCK_CYC`.
- State machine with states WAIT_LOCK, IDLE, RUN, STOPPING:
  - WAIT_LOCK → IDLE when `ready` rises.
  - IDLE → RUN when `clk_en`=1. On this transition `cnt` is set to 0.
  - RUN → STOPPING when `clk_en`=0 and `sd_clk`=1.
  - RUN → IDLE when `clk_en`=0 and `sd_clk`=0.
  - STOPPING → IDLE on the falling toggle. The high phase completes, so there are no runt pulses.
  - Any state → WAIT_LOCK when the synchronised lock reads 0. `sd_clk` is forced to 0 on the next edge. The only truncated pulse permitted is on lock loss.
- Divider:
  - `cnt` is DIV_W bits wide.
  - In RUN and STOPPING, when `cnt==cur_div`: toggle `sd_clk` and set `cnt` to 0. Otherwise increment `cnt`.
  - In other states `cnt` is 0 and `sd_clk` is 0.
- Divisor update:
  - `div_load` writes `div_val` into `pend_div` and sets `pend`.
  - A load while `pend` is already set overwrites it; the last value wins.
  - `pend_div` is transferred to `cur_div` either on the cycle `sd_clk` toggles 1→0, or at the next cycle while in IDLE or WAIT_LOCK. `div_done` pulses on the transfer and `pend` clears.
  - If `div_load` arrives in the same cycle as a transfer, the old pending value transfers and the new value stays pending.
- Strobes:
  - `pos_stb` and `neg_stb` are registered alongside `sd_clk`, so each coincides exactly with the new `sd_clk` level.
  - The forced low on lock loss does not raise `neg_stb`.
- `clk_en` changes during the low phase take effect at the next cycle. Changes during the high phase take effect at the following fall.

## Timing
- Reset values:
  - `sd_clk`, `pos_stb`, `neg_stb`, `div_done`, `ready`, `running` = 0.
  - State = WAIT_LOCK, `cur_div` = `INIT_DIV`, `pend` = 0, `cnt` = 0, lock counter = 0.
- `ready` latency: rises 2 + `LOCK_CYC` cycles after `pll_lock` rises and stays high.
- Start latency: the first `sd_clk` rise comes `cur_div+1` cycles after the cycle in which RUN is entered.
- Period: `2*(cur_div+1)` clk cycles.
  - `div=0` gives clk/2 with a strobe every cycle, alternating between `pos_stb` and `neg_stb`.
  - Maximum divisor is 2^DIV_W−1.
- `running` is registered with the state.

## Test plan
- Lock qualification, with `LOCK_CYC`=8: release reset, hold `pll_lock`=1.
  - `ready`=1 exactly 10 cycles later.
  - A 1-cycle `pll_lock` drop at cycle 5 delays `ready` by a full requalification.
- Default rate: `clk_en`=1, divisor 62.
  - `sd_clk` period is 126 clk cycles, with 63 high and 63 low.
  - `pos_stb` pulses exactly once per period, each time coinciding with `sd_clk` rising.
- Divisor switch: load 0 mid high phase while at divisor 62.
  - The high phase still lasts 63 cycles.
  - `div_done` pulses at the fall.
  - From then on the period is 2 cycles.
  - Two loads (5, then 1) within one high phase: only 1 is applied.
- Stop and restart:
  - Deassert `clk_en` 10 cycles into a high phase: `sd_clk` stays high 53 more cycles, `neg_stb` pulses once, then `running`=0.
  - Reassert `clk_en`: the first rise comes `cur_div+1` cycles later.
- Lock loss while running at divisor 3:
  - `sd_clk` reads 0 three cycles after the `pll_lock` drop (two synchroniser cycles, one output register), with no `neg_stb`, and the block enters WAIT_LOCK.
  - It resumes only after requalification and with `clk_en` still high.
- Reset mid-run: assert `rst_n`=0 asynchronously in any phase.
  - All outputs go to 0 immediately and `cur_div` returns to 62.
